// File: rtl/eight_row_packer.sv
// Serial-to-parallel front end for the eight-lane row accumulator: packs 32-bit
// elements into NI-lane chunks, zero-pads each row's tail chunk, hands off via valid/ready.
module eight_row_packer #(
    parameter int NI    = 8,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              start,
    input  logic [LEN_W-1:0]  row_length,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NI*32-1:0]  adder_row_input,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              chunk_strobe,
    output logic [LEN_W-1:0]  chunk_index
);

    localparam int LW = $clog2(NI);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STALL
    } state_t;

    state_t                  r_state;
    logic [NI-1:0][31:0]     r_pack;
    logic [LW-1:0]           r_lane_cnt;
    logic [LEN_W-1:0]        r_elem_cnt;
    logic [LEN_W-1:0]        r_len_q;
    logic                    r_pack_last;
    logic                    r_run;
    logic [NI*32-1:0]        r_out_data;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_strobe;
    logic [LEN_W-1:0]        r_out_idx;
    logic [LEN_W-1:0]        r_next_idx;

    logic                    w_out_free;
    logic                    w_stalled;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_row_start;
    logic [LEN_W-1:0]        w_len;
    logic [LEN_W-1:0]        w_cnt_now;
    logic                    w_row_end;
    logic                    w_close;
    logic                    w_xfer_pack;
    logic                    w_xfer_new;
    logic                    w_load;
    logic                    w_load_last;
    logic [NI*32-1:0]        w_load_data;
    logic [NI-1:0][31:0]     w_filled;

    assign w_out_free  = !r_out_valid || out_ready;
    assign w_stalled   = (r_state == STALL);
    assign w_in_ready  = r_run && !(w_stalled && !w_out_free);
    assign w_accept    = in_valid && w_in_ready;
    // A row opens on the first accept when idle or when the stalled chunk ended a row.
    assign w_row_start = (r_state == IDLE) || (w_stalled && r_pack_last);
    assign w_len       = w_row_start ? ((row_length == '0) ? LEN_W'(1) : row_length) : r_len_q;
    assign w_cnt_now   = (w_row_start ? '0 : r_elem_cnt) + LEN_W'(1);
    assign w_row_end   = (w_cnt_now == w_len);
    assign w_close     = w_accept && (w_row_end || (r_lane_cnt == LW'(NI - 1)));

    assign w_xfer_pack = w_stalled && w_out_free;
    assign w_xfer_new  = w_close && !w_stalled && w_out_free;
    assign w_load      = w_xfer_pack || w_xfer_new;
    assign w_load_data = w_xfer_pack ? r_pack : w_filled;
    assign w_load_last = w_xfer_pack ? r_pack_last : w_row_end;

    // Starting a fresh chunk clears every lane, so padding falls out naturally at row end.
    always_comb begin
        w_filled = (r_lane_cnt == '0) ? '0 : r_pack;
        w_filled[r_lane_cnt] = in_data;
    end

    always_ff @(posedge clk) begin
        if (!start) begin
            r_state     <= IDLE;
            r_pack      <= '0;
            r_lane_cnt  <= '0;
            r_elem_cnt  <= '0;
            r_len_q     <= '0;
            r_pack_last <= 1'b0;
            r_run       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_strobe    <= 1'b0;
            r_out_idx   <= '0;
            r_next_idx  <= '0;
        end else begin
            r_run    <= 1'b1;
            r_strobe <= r_out_valid && out_ready;

            if (w_accept) begin
                r_len_q    <= w_len;
                r_elem_cnt <= w_cnt_now;
                r_lane_cnt <= w_close ? '0 : r_lane_cnt + LW'(1);
            end

            if (w_load) begin
                r_out_data  <= w_load_data;
                r_out_valid <= 1'b1;
                r_out_last  <= w_load_last;
                r_out_idx   <= r_next_idx;
                r_next_idx  <= w_load_last ? '0 : r_next_idx + LEN_W'(1);
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            // In STALL a transfer refills the output register, so a same-cycle close must stall again.
            case (r_state)
                IDLE, FILL: begin
                    if (w_accept) begin
                        if (w_close && !w_out_free) begin
                            r_state     <= STALL;
                            r_pack      <= w_filled;
                            r_pack_last <= w_row_end;
                        end else if (w_close) begin
                            r_state <= w_row_end ? IDLE : FILL;
                        end else begin
                            r_state <= FILL;
                            r_pack  <= w_filled;
                        end
                    end
                end
                STALL: begin
                    if (w_out_free) begin
                        if (w_accept && w_close) begin
                            r_state     <= STALL;
                            r_pack      <= w_filled;
                            r_pack_last <= w_row_end;
                        end else if (w_accept) begin
                            r_state <= FILL;
                            r_pack  <= w_filled;
                        end else begin
                            r_state <= r_pack_last ? IDLE : FILL;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready        = w_in_ready;
    assign adder_row_input = r_out_data;
    assign out_valid       = r_out_valid;
    assign out_last        = r_out_last;
    assign chunk_strobe    = r_strobe;
    assign chunk_index     = r_out_idx;

endmodule

// File: tb/tb_eight_row_packer.sv
// Self-checking bench for eight_row_packer: directed scenarios plus randomized rows
// compared against a row-to-chunk reference model built from queues.
module tb_eight_row_packer;

    localparam int NI    = 8;
    localparam int LEN_W = 16;

    logic              clk = 1'b0;
    logic              start;
    logic [LEN_W-1:0]  row_length;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [NI*32-1:0]  adder_row_input;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              chunk_strobe;
    logic [LEN_W-1:0]  chunk_index;

    always #5 clk = ~clk;

    eight_row_packer #(.NI(NI), .LEN_W(LEN_W)) dut (
        .clk             (clk),
        .start           (start),
        .row_length      (row_length),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .adder_row_input (adder_row_input),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .chunk_strobe    (chunk_strobe),
        .chunk_index     (chunk_index)
    );

    typedef struct {
        logic [NI*32-1:0] data;
        logic             last;
        logic [LEN_W-1:0] idx;
    } chunk_t;

    chunk_t           expQ[$];
    logic [31:0]      elemQ[$];
    logic [LEN_W-1:0] lenQ[$];
    logic [31:0]      rowVals[$];
    int               checkCount = 0;
    int               passCount  = 0;

    // Reference model: a row of max(len,1) elements splits into ceil(n/NI) chunks, tail zero-filled.
    task automatic add_row(input int len);
        int eff     = (len == 0) ? 1 : len;
        int nChunks = (eff + NI - 1) / NI;
        for (int c = 0; c < nChunks; c++) begin
            chunk_t ch;
            ch.data = '0;
            for (int k = 0; k < NI; k++) begin
                if (c * NI + k < eff) ch.data[k*32 +: 32] = rowVals[c * NI + k];
            end
            ch.last = (c == nChunks - 1);
            ch.idx  = LEN_W'(c);
            expQ.push_back(ch);
        end
        for (int e = 0; e < eff; e++) begin
            elemQ.push_back(rowVals[e]);
            lenQ.push_back((e == 0) ? LEN_W'(len) : LEN_W'($urandom));
        end
    endtask

    task automatic fill_random_row(input int len);
        int eff = (len == 0) ? 1 : len;
        rowVals.delete();
        for (int e = 0; e < eff; e++) rowVals.push_back($urandom);
    endtask

    task automatic run_traffic(input int inPct, input int outPct, input int maxCycles, output int stallCycles);
        int               cycles   = 0;
        logic             prevHs   = 1'b0;
        logic             prevHold = 1'b0;
        logic [NI*32-1:0] prevData = '0;
        logic             prevLast = 1'b0;
        logic [LEN_W-1:0] prevIdx  = '0;
        stallCycles = 0;
        while ((elemQ.size() > 0 || expQ.size() > 0) && cycles < maxCycles) begin
            @(negedge clk);
            cycles++;
            in_valid   = (elemQ.size() > 0) && ($urandom_range(99) < inPct);
            in_data    = in_valid ? elemQ[0] : $urandom;
            row_length = in_valid ? lenQ[0] : LEN_W'($urandom);
            out_ready  = ($urandom_range(99) < outPct);
            #1;
            checkCount++;
            if (chunk_strobe !== prevHs)
                $display("[TB] FAIL strobe: got %b expected %b", chunk_strobe, prevHs);
            else passCount++;
            if (prevHold) begin
                checkCount++;
                if (out_valid !== 1'b1 || adder_row_input !== prevData || out_last !== prevLast || chunk_index !== prevIdx)
                    $display("[TB] FAIL hold: got valid=%b data=%h last=%b idx=%0d expected valid=1 data=%h last=%b idx=%0d",
                             out_valid, adder_row_input, out_last, chunk_index, prevData, prevLast, prevIdx);
                else passCount++;
            end
            if (out_valid && out_ready) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL chunk: got unexpected chunk data=%h expected no chunk", adder_row_input);
                end else begin
                    if (adder_row_input !== expQ[0].data || out_last !== expQ[0].last || chunk_index !== expQ[0].idx)
                        $display("[TB] FAIL chunk: got data=%h last=%b idx=%0d expected data=%h last=%b idx=%0d",
                                 adder_row_input, out_last, chunk_index, expQ[0].data, expQ[0].last, expQ[0].idx);
                    else passCount++;
                    void'(expQ.pop_front());
                end
            end
            if (in_valid && !in_ready) stallCycles++;
            if (in_valid && in_ready) begin
                void'(elemQ.pop_front());
                void'(lenQ.pop_front());
            end
            prevHs   = out_valid && out_ready;
            prevHold = out_valid && !out_ready;
            prevData = adder_row_input;
            prevLast = out_last;
            prevIdx  = chunk_index;
        end
        if (elemQ.size() > 0 || expQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL timeout: got %0d elements and %0d chunks outstanding expected 0", elemQ.size(), expQ.size());
            elemQ.delete();
            lenQ.delete();
            expQ.delete();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checkCount++;
        if (chunk_strobe !== prevHs)
            $display("[TB] FAIL strobe_tail: got %b expected %b", chunk_strobe, prevHs);
        else passCount++;
    endtask

    task automatic test_reset();
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        row_length = '0;
        repeat (3) @(negedge clk);
        #1;
        checkCount++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || chunk_strobe !== 1'b0 ||
            chunk_index !== '0 || adder_row_input !== '0)
            $display("[TB] FAIL reset: got rdy=%b vld=%b last=%b stb=%b idx=%0d data=%h expected all zero",
                     in_ready, out_valid, out_last, chunk_strobe, chunk_index, adder_row_input);
        else passCount++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_release: got in_ready=%b expected 1", in_ready);
        else passCount++;
    endtask

    task automatic test_single_chunk();
        logic [31:0]      f [8];
        logic [NI*32-1:0] expData;
        f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        for (int k = 0; k < NI; k++) expData[k*32 +: 32] = f[k];
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_data    = f[i];
            row_length = (i == 0) ? LEN_W'(8) : LEN_W'($urandom);
            #1;
            checkCount++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0)
                $display("[TB] FAIL single_fill: got in_ready=%b out_valid=%b expected 1/0 at element %0d", in_ready, out_valid, i);
            else passCount++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b1 || adder_row_input !== expData || out_last !== 1'b1 || chunk_index !== '0 || chunk_strobe !== 1'b0)
            $display("[TB] FAIL single_chunk: got vld=%b data=%h last=%b idx=%0d stb=%b expected 1 %h 1 0 0",
                     out_valid, adder_row_input, out_last, chunk_index, chunk_strobe, expData);
        else passCount++;
        @(negedge clk);
        #1;
        checkCount++;
        if (chunk_strobe !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL single_strobe: got stb=%b vld=%b expected 1/0", chunk_strobe, out_valid);
        else passCount++;
        @(negedge clk);
        #1;
        checkCount++;
        if (chunk_strobe !== 1'b0) $display("[TB] FAIL single_strobe_end: got %b expected 0", chunk_strobe);
        else passCount++;
        out_ready = 1'b0;
    endtask

    task automatic test_padding();
        int stalls;
        rowVals.delete();
        for (int e = 1; e <= 11; e++) rowVals.push_back(32'(e));
        add_row(11);
        run_traffic(100, 100, 100, stalls);
    endtask

    task automatic test_backpressure();
        int               accepted = 0;
        int               stalls;
        logic             haveHeld = 1'b0;
        logic [NI*32-1:0] held     = '0;
        fill_random_row(24);
        add_row(24);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready  = 1'b0;
            in_valid   = 1'b1;
            in_data    = elemQ[0];
            row_length = lenQ[0];
            #1;
            if (out_valid && !haveHeld) begin
                held     = adder_row_input;
                haveHeld = 1'b1;
            end
            if (in_valid && in_ready) begin
                void'(elemQ.pop_front());
                void'(lenQ.pop_front());
                accepted++;
            end
        end
        checkCount++;
        if (accepted !== 16 || in_ready !== 1'b0)
            $display("[TB] FAIL bp_stall: got accepted=%0d in_ready=%b expected 16/0", accepted, in_ready);
        else passCount++;
        checkCount++;
        if (out_valid !== 1'b1 || adder_row_input !== expQ[0].data || adder_row_input !== held || out_last !== 1'b0)
            $display("[TB] FAIL bp_hold: got vld=%b data=%h last=%b expected 1 %h 0", out_valid, adder_row_input, out_last, expQ[0].data);
        else passCount++;
        run_traffic(100, 100, 200, stalls);
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL bp_resume: got in_ready=%b expected 1", in_ready);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int stalls;
        fill_random_row(3);
        add_row(3);
        fill_random_row(8);
        add_row(8);
        run_traffic(100, 100, 100, stalls);
        checkCount++;
        if (stalls !== 0) $display("[TB] FAIL b2b_gap: got %0d stalled input cycles expected 0", stalls);
        else passCount++;
    endtask

    task automatic test_reset_mid_row();
        int stalls;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_data    = 32'hDEAD0000 + 32'(i);
            row_length = (i == 0) ? LEN_W'(8) : LEN_W'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        #1;
        checkCount++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || chunk_strobe !== 1'b0 ||
            chunk_index !== '0 || adder_row_input !== '0)
            $display("[TB] FAIL mid_reset: got rdy=%b vld=%b last=%b stb=%b idx=%0d data=%h expected all zero",
                     in_ready, out_valid, out_last, chunk_strobe, chunk_index, adder_row_input);
        else passCount++;
        start     = 1'b1;
        out_ready = 1'b0;
        fill_random_row(8);
        add_row(8);
        run_traffic(100, 100, 100, stalls);
    endtask

    task automatic test_zero_length();
        int stalls;
        rowVals.delete();
        rowVals.push_back(32'h40400000);
        add_row(0);
        run_traffic(100, 100, 100, stalls);
    endtask

    task automatic test_random_rows();
        int stalls;
        for (int r = 0; r < 14; r++) begin
            int len = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(40, 1));
            fill_random_row(len);
            add_row(len);
        end
        run_traffic(70, 60, 5000, stalls);
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_padding();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_row();
        test_zero_length();
        test_random_rows();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/eight_row_packer.md
Name: eight_row_packer

Overview:
- Serial-to-parallel front end for the eight-lane row accumulator.
- Accepts one 32-bit single-precision element per cycle and packs elements into NI-lane chunks.
- Zero-pads the final chunk of each row.
- Presents each chunk with a valid/ready handshake plus a row-last flag; the accept pulse drives the accumulator's chunk strobe.

Parameters:
- NI, 8, lanes per chunk (power of two, 2..16).
- LEN_W, 16, width of the row-length field.

Ports:
- clk  input  1  rising-edge clock.
- start  input  1  synchronous active-low reset; 0 clears the block, 1 runs.
- row_length  input  LEN_W  elements in the row; sampled with the first accepted element of each row.
- in_data  input  32  element; element 0 of a chunk goes to lane 0.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- adder_row_input  output  NI*32  packed chunk; lane k occupies bits [32k+31:32k].
- out_valid  output  1  chunk held on adder_row_input.
- out_ready  input  1  downstream takes the chunk.
- out_last  output  1  chunk is the final chunk of its row.
- chunk_strobe  output  1  registered copy of (out_valid & out_ready), one-cycle pulse.
- chunk_index  output  LEN_W  chunk number within the current row, starting at 0.

Behaviour:
- Reset (start=0 at a clock edge):
  - in_ready, out_valid, out_last, chunk_strobe, chunk_index = 0; adder_row_input = 0.
  - Pack register, lane counter and element counter are cleared.
  - A partially packed row is discarded.
  - in_ready goes to 1 on the first edge with start=1.
- Storage: one pack register (filling) plus one output register (held for downstream). Sustained throughput is one element per cycle.
- Element accept: in_valid & in_ready. The element is written into lane lane_cnt and lane_cnt increments.
- Row start: the first accept after reset, or after a row completes, latches row_length into len_q and clears the element counter.
  - len_q = 0 is treated as 1.
- Chunk close: the chunk closes on the accept that fills lane NI-1, or on the accept of the element whose count equals len_q.
  - On a close at the row end, all unwritten lanes are forced to 32'h00000000.
  - out_last is set for that chunk.
  - Lanes are never carried over between rows.
- Transfer into the output register happens on the close edge if the output register is empty or being drained in that same cycle.
  - Latency: the closing element accepted at edge t gives out_valid=1 after edge t.
  - Otherwise the closed chunk waits in the pack register with in_ready=0 until the transfer occurs.
- in_ready = 0 only while the pack register holds a closed chunk that cannot transfer. It is combinational from out_ready, so drain and accept in the same cycle are allowed.
- Output: out_valid, adder_row_input, out_last and chunk_index stay stable until out_valid & out_ready.
  - out_valid falls on that edge unless a new chunk transfers on the same edge.
  - chunk_strobe pulses for exactly one cycle after each handshake.
- chunk_index increments per transferred chunk and returns to 0 after an out_last chunk.
- State machine:
  - IDLE: no row open → FILL on the first accept.
  - FILL: → STALL on a close with the output register full and not draining; → IDLE after a row-end close that transfers.
  - STALL: → FILL or IDLE when the transfer occurs.
- Values are passed bit-exact; there is no arithmetic and no NaN/denormal handling.
- Element counter width is LEN_W. A row of 2^LEN_W−1 elements must work without overflow.

Test Plan:
- Single full chunk:
  - Stimulus: start=1, row_length=8, elements 1.0..8.0 (32'h3F800000..32'h41000000) on consecutive cycles, out_ready=1.
  - Required: one chunk, lane 0=32'h3F800000, lane 7=32'h41000000, out_last=1, chunk_index=0, out_valid one cycle after the 8th accept, chunk_strobe one cycle after that.
- Padding:
  - Stimulus: row_length=11, elements 1..11.
  - Required: chunk 0 has lanes 1..8 with out_last=0; chunk 1 has lanes 9,10,11 then five lanes of 32'h0 with out_last=1 and chunk_index=1.
- Backpressure:
  - Stimulus: row_length=24, out_ready=0 throughout.
  - Required: the first chunk is held stable; in_ready drops after the 16th accept; no data is lost. Then out_ready=1 gives chunks 2 and 3 in order and in_ready returns high.
- Back-to-back rows:
  - Stimulus: rows of lengths 3 then 8 streamed with no gap, out_ready=1.
  - Required: chunk A = {e0,e1,e2,0,0,0,0,0} with last=1; chunk B holds the 8 new elements with last=1; no idle input cycle.
- Reset mid-row:
  - Stimulus: after 5 of 8 elements, start=0 for one cycle, then a new row of length 8.
  - Required: all outputs 0 during reset; the first chunk out contains only the new row's elements.
- Zero length:
  - Stimulus: row_length=0 with one element 32'h40400000.
  - Required: a single chunk with lane 0=32'h40400000, other lanes 0, out_last=1.
